// File: rtl/mem_bus_responder.sv
// Memory-side endpoint of the L1 coherence bus: turns bus requests into one
// memory access at a time and returns the completion message with line data.
module mem_bus_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MSG_BITS   = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [MSG_BITS-1:0]   bus_msg,
    input  logic [ADDR_WIDTH-1:0] bus_address,
    input  logic [DATA_WIDTH-1:0] bus_data,
    input  logic                  req_ready,
    output logic [MSG_BITS-1:0]   mem2controller_msg,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    output logic [ADDR_WIDTH-1:0] mem_address_out,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  timeout_err
);

    localparam logic [MSG_BITS-1:0] NO_REQ     = MSG_BITS'(0);
    localparam logic [MSG_BITS-1:0] R_REQ      = MSG_BITS'(1);
    localparam logic [MSG_BITS-1:0] RFO_BCAST  = MSG_BITS'(2);
    localparam logic [MSG_BITS-1:0] WB_REQ     = MSG_BITS'(3);
    localparam logic [MSG_BITS-1:0] FLUSH      = MSG_BITS'(4);
    localparam logic [MSG_BITS-1:0] FLUSH_S    = MSG_BITS'(5);
    localparam logic [MSG_BITS-1:0] C_WB       = MSG_BITS'(6);
    localparam logic [MSG_BITS-1:0] C_FLUSH    = MSG_BITS'(7);
    localparam logic [MSG_BITS-1:0] MEM_RESP   = MSG_BITS'(8);
    localparam logic [MSG_BITS-1:0] MEM_RESP_S = MSG_BITS'(9);
    localparam logic [MSG_BITS-1:0] MEM_C_RESP = MSG_BITS'(10);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, MEM_ACCESS, RESPOND} state_t;

    state_t                state_q, state_d;
    logic [MSG_BITS-1:0]   code_q, code_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [MSG_BITS-1:0]   msg_d;
    logic [DATA_WIDTH-1:0] data_d, wdata_d;
    logic [ADDR_WIDTH-1:0] addr_d, aout_d;
    logic                  req_d, we_d, err_d;

    logic is_coh, is_wr, is_rd, write_op;
    logic [MSG_BITS-1:0] accept_code;

    // Coherence traffic bypasses req_ready; priority is coherence > write > read.
    assign is_coh   = (bus_msg == C_WB) || (bus_msg == C_FLUSH);
    assign is_wr    = req_ready && ((bus_msg == WB_REQ) || (bus_msg == FLUSH) || (bus_msg == FLUSH_S));
    assign is_rd    = req_ready && ((bus_msg == R_REQ) || (bus_msg == RFO_BCAST));
    assign write_op = is_coh || is_wr;
    assign accept_code = is_coh ? MEM_C_RESP :
                         (is_wr && bus_msg == FLUSH_S) ? MEM_RESP_S : MEM_RESP;

    // Memory handshake: mem_req is level-held with mem_we/mem_addr/mem_wdata
    // stable until a single-cycle mem_ack completes it; mem_ack is ignored
    // whenever mem_req is low.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        msg_d   = mem2controller_msg;
        data_d  = mem_data_out;
        aout_d  = mem_address_out;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        req_d   = mem_req;
        we_d    = mem_we;
        err_d   = timeout_err;
        case (state_q)
            IDLE: begin
                if (is_coh || is_wr || is_rd) begin
                    state_d = MEM_ACCESS;
                    req_d   = 1'b1;
                    we_d    = write_op;
                    addr_d  = bus_address;
                    aout_d  = bus_address;
                    if (write_op) wdata_d = bus_data;
                    code_d  = accept_code;
                    cnt_d   = '0;
                end
            end
            MEM_ACCESS: begin
                if (mem_ack) begin
                    req_d   = 1'b0;
                    data_d  = mem_we ? mem_wdata : mem_rdata;
                    msg_d   = code_q;
                    state_d = RESPOND;
                end else begin
                    // Watchdog only flags; the access keeps waiting for its ack.
                    if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CW'(TIMEOUT)) err_d = 1'b1;
                end
            end
            RESPOND: begin
                if (bus_msg == NO_REQ) begin
                    msg_d   = NO_REQ;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q            <= IDLE;
            code_q             <= NO_REQ;
            cnt_q              <= '0;
            mem2controller_msg <= NO_REQ;
            mem_data_out       <= '0;
            mem_address_out    <= '0;
            mem_addr           <= '0;
            mem_wdata          <= '0;
            mem_req            <= 1'b0;
            mem_we             <= 1'b0;
            timeout_err        <= 1'b0;
        end else begin
            state_q            <= state_d;
            code_q             <= code_d;
            cnt_q              <= cnt_d;
            mem2controller_msg <= msg_d;
            mem_data_out       <= data_d;
            mem_address_out    <= aout_d;
            mem_addr           <= addr_d;
            mem_wdata          <= wdata_d;
            mem_req            <= req_d;
            mem_we             <= we_d;
            timeout_err        <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized bench for mem_bus_responder: a transaction-level reference model
// is compared against every output each cycle, plus directed literal checks.
module tb_mem_bus_responder;

    localparam int TO = 4;

    localparam logic [3:0] NO_REQ     = 4'd0;
    localparam logic [3:0] R_REQ      = 4'd1;
    localparam logic [3:0] RFO_BCAST  = 4'd2;
    localparam logic [3:0] WB_REQ     = 4'd3;
    localparam logic [3:0] FLUSH      = 4'd4;
    localparam logic [3:0] FLUSH_S    = 4'd5;
    localparam logic [3:0] C_WB       = 4'd6;
    localparam logic [3:0] C_FLUSH    = 4'd7;
    localparam logic [3:0] MEM_RESP   = 4'd8;
    localparam logic [3:0] MEM_RESP_S = 4'd9;
    localparam logic [3:0] MEM_C_RESP = 4'd10;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  bus_msg;
    logic [31:0] bus_address, bus_data;
    logic        req_ready;
    logic [3:0]  mem2controller_msg;
    logic [31:0] mem_data_out, mem_address_out, mem_addr, mem_wdata, mem_rdata;
    logic        mem_req, mem_we, mem_ack, timeout_err;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    mem_bus_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MSG_BITS(4), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .bus_msg(bus_msg), .bus_address(bus_address),
        .bus_data(bus_data), .req_ready(req_ready), .mem2controller_msg(mem2controller_msg),
        .mem_data_out(mem_data_out), .mem_address_out(mem_address_out), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction described by flags.
    bit          m_busy, m_resp, m_we, m_err;
    logic [3:0]  m_msg, m_code;
    logic [31:0] m_addr, m_wdata, m_data;
    int          m_wait;

    function automatic void classify(input logic [3:0] m, input logic rr,
                                     output bit acc, output bit wr, output logic [3:0] code);
        acc = 1'b0; wr = 1'b0; code = MEM_RESP;
        case (m)
            C_WB, C_FLUSH:   begin acc = 1'b1; wr = 1'b1; code = MEM_C_RESP; end
            WB_REQ, FLUSH:   begin acc = rr;   wr = 1'b1; code = MEM_RESP;   end
            FLUSH_S:         begin acc = rr;   wr = 1'b1; code = MEM_RESP_S; end
            R_REQ, RFO_BCAST: begin acc = rr;  wr = 1'b0; code = MEM_RESP;   end
            default: acc = 1'b0;
        endcase
    endfunction

    initial forever begin
        bit acc, wr;
        logic [3:0] code;
        @(posedge clock);
        if (reset) begin
            m_busy = 0; m_resp = 0; m_we = 0; m_err = 0; m_msg = NO_REQ; m_code = NO_REQ;
            m_addr = 0; m_wdata = 0; m_data = 0; m_wait = 0;
        end else if (m_busy) begin
            if (mem_ack) begin
                m_busy = 0; m_resp = 1;
                m_data = m_we ? m_wdata : mem_rdata;
                m_msg  = m_code;
            end else begin
                if (m_wait < TO) m_wait++;
                if (m_wait >= TO) m_err = 1;
            end
        end else if (m_resp) begin
            if (bus_msg == NO_REQ) begin m_resp = 0; m_msg = NO_REQ; end
        end else begin
            classify(bus_msg, req_ready, acc, wr, code);
            if (acc) begin
                m_busy = 1; m_we = wr; m_addr = bus_address; m_code = code; m_wait = 0;
                if (wr) m_wdata = bus_data;
            end
        end
    end

    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            check("msg",       {28'd0, mem2controller_msg}, {28'd0, m_msg});
            check("data_out",  mem_data_out, m_data);
            check("addr_out",  mem_address_out, m_addr);
            check("mem_addr",  mem_addr, m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
            check("mem_req",   {31'd0, mem_req}, {31'd0, m_busy});
            check("mem_we",    {31'd0, mem_we}, {31'd0, m_we});
            check("timeout",   {31'd0, timeout_err}, {31'd0, m_err});
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_write(input logic [3:0] msg, input logic rr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] code);
        bus_msg = msg; req_ready = rr; bus_address = a; bus_data = d;
        tick();
        check("wr_req",   {31'd0, mem_req}, 32'd1);
        check("wr_we",    {31'd0, mem_we}, 32'd1);
        check("wr_addr",  mem_addr, a);
        check("wr_wdata", mem_wdata, d);
        bus_msg = NO_REQ; req_ready = 1'b0; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("wr_resp",  {28'd0, mem2controller_msg}, {28'd0, code});
        check("wr_data",  mem_data_out, d);
        check("wr_done",  {31'd0, mem_req}, 32'd0);
        tick();
        check("wr_noreq", {28'd0, mem2controller_msg}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; bus_msg = NO_REQ; bus_address = 0; bus_data = 0;
        req_ready = 1'b0; mem_rdata = 0; mem_ack = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        check("rst_msg",  {28'd0, mem2controller_msg}, 32'd0);
        check("rst_req",  {31'd0, mem_req}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_err",  {31'd0, timeout_err}, 32'd0);
        reset = 1'b0;

        // Read, with bus changes ignored while the access is outstanding.
        bus_msg = R_REQ; req_ready = 1'b1; bus_address = 32'h100;
        tick();
        check("rd_req",  {31'd0, mem_req}, 32'd1);
        check("rd_we",   {31'd0, mem_we}, 32'd0);
        check("rd_addr", mem_addr, 32'h100);
        bus_msg = WB_REQ; bus_address = 32'h999; bus_data = 32'h55;
        tick(); tick();
        check("rd_hold_addr", mem_addr, 32'h100);
        check("rd_hold_we",   {31'd0, mem_we}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        check("rd_resp", {28'd0, mem2controller_msg}, {28'd0, MEM_RESP});
        check("rd_data", mem_data_out, 32'hDEADBEEF);
        check("rd_dropreq", {31'd0, mem_req}, 32'd0);
        tick();
        check("rsp_hold", {28'd0, mem2controller_msg}, {28'd0, MEM_RESP});
        check("rsp_noacc", {31'd0, mem_req}, 32'd0);
        bus_msg = NO_REQ;
        tick();
        check("rd_noreq", {28'd0, mem2controller_msg}, 32'd0);
        check("rd_idle_req", {31'd0, mem_req}, 32'd0);

        do_write(WB_REQ,  1'b1, 32'h40, 32'h12345678, MEM_RESP);
        do_write(FLUSH_S, 1'b1, 32'h40, 32'h12345678, MEM_RESP_S);
        do_write(C_FLUSH, 1'b0, 32'h80, 32'hA5A5A5A5, MEM_C_RESP);

        bus_msg = R_REQ; req_ready = 1'b0; bus_address = 32'h200;
        tick(); tick();
        check("rd_not_ready", {31'd0, mem_req}, 32'd0);
        bus_msg = NO_REQ;

        // Watchdog: flags after TO waiting edges, sticky through completion.
        bus_msg = C_WB; bus_data = 32'h77; bus_address = 32'h300;
        tick();
        bus_msg = NO_REQ;
        tick(); tick(); tick();
        check("to_early", {31'd0, timeout_err}, 32'd0);
        tick();
        check("to_set", {31'd0, timeout_err}, 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("to_resp", {28'd0, mem2controller_msg}, {28'd0, MEM_C_RESP});
        tick();
        check("to_sticky", {31'd0, timeout_err}, 32'd1);

        // Reset during an outstanding access; a late ack is ignored.
        bus_msg = R_REQ; req_ready = 1'b1; bus_address = 32'h400;
        tick();
        bus_msg = NO_REQ;
        check("mid_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
        check("mid_rst_req",  {31'd0, mem_req}, 32'd0);
        check("mid_rst_addr", mem_addr, 32'd0);
        check("mid_rst_err",  {31'd0, timeout_err}, 32'd0);
        tick();
        mem_ack = 1'b0;
        check("late_ack", {28'd0, mem2controller_msg}, 32'd0);
        check("late_ack_data", mem_data_out, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 99) == 0);
            bus_msg     = ($urandom_range(0, 2) == 0) ? NO_REQ : 4'($urandom_range(0, 15));
            req_ready   = 1'($urandom_range(0, 1));
            bus_address = $urandom;
            bus_data    = $urandom;
            mem_rdata   = $urandom;
            mem_ack     = ($urandom_range(0, 3) == 0);
            tick();
        end
        reset = 1'b0; mem_ack = 1'b0; bus_msg = NO_REQ;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
